// File: rtl/alu181_nibble_sequencer.sv
// alu181_nibble_sequencer: drives one 4-bit 74181 slice nibble-serially, LSB nibble first, chaining carry.
// Optional ALU_SEQ_OVERFLOW_EN adds a signed-overflow flag (out_ovf) for A plus B and A minus B.
module alu181_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_select,
   input  logic             in_mode,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_f,
   output logic             out_cout,
   output logic             out_zero,
`ifdef ALU_SEQ_OVERFLOW_EN
   output logic             out_ovf,
`endif
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_select,
   output logic             alu_mode,
   output logic             alu_cin,
   input  logic [3:0]       alu_f,
   input  logic             alu_cout
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [3:0]       sel_q, sel_d;
   logic             mode_q, mode_d, carry_q, carry_d, zero_q, zero_d, run;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ALU_SEQ_OVERFLOW_EN
   logic             cin_q, cin_d, am_q, am_d, bm_q, bm_d, ovf_q, ovf_d, is_add, is_sub;
`endif
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sel_d   = sel_q;
      mode_d  = mode_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
`ifdef ALU_SEQ_OVERFLOW_EN
      cin_d   = cin_q;
      am_d    = am_q;
      bm_d    = bm_q;
      ovf_d   = ovf_q;
      is_add  = !mode_q && sel_q == 4'b1001 && cin_q;
      is_sub  = !mode_q && sel_q == 4'b0110 && !cin_q;
`endif
      if (state_q == IDLE && in_valid) begin
         state_d = RUN;
         a_d     = in_a;
         b_d     = in_b;
         sel_d   = in_select;
         mode_d  = in_mode;
         carry_d = in_cin;
         cnt_d   = '0;
`ifdef ALU_SEQ_OVERFLOW_EN
         cin_d   = in_cin;
         am_d    = in_a[WIDTH-1];
         bm_d    = in_b[WIDTH-1];
`endif
      end else if (state_q == RUN) begin
         a_d     = a_q >> 4;
         b_d     = b_q >> 4;
         res_d   = WIDTH'({alu_f, res_q} >> 4);
         carry_d = alu_cout;
         cnt_d   = cnt_q + 1'b1;
         if (cnt_q == CW'(NIBBLES - 1)) begin
            state_d = DONE;
            zero_d  = res_d == '0;
`ifdef ALU_SEQ_OVERFLOW_EN
            ovf_d   = is_add ? (am_q == bm_q && alu_f[3] != am_q) :
                      is_sub ? (am_q != bm_q && alu_f[3] != am_q) : 1'b0;
`endif
         end
      end else if (state_q == DONE && out_ready) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sel_q   <= '0;
         mode_q  <= 1'b0;
         carry_q <= 1'b1;
         zero_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef ALU_SEQ_OVERFLOW_EN
         cin_q   <= 1'b1;
         am_q    <= 1'b0;
         bm_q    <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sel_q   <= sel_d;
         mode_q  <= mode_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         cnt_q   <= cnt_d;
`ifdef ALU_SEQ_OVERFLOW_EN
         cin_q   <= cin_d;
         am_q    <= am_d;
         bm_q    <= bm_d;
         ovf_q   <= ovf_d;
`endif
      end
   end
   assign run        = state_q == RUN;
   assign in_ready   = state_q == IDLE;
   assign out_valid  = state_q == DONE;
   assign out_f      = res_q;
   // the carry register holds the top nibble's carry-out once RUN finishes
   assign out_cout   = mode_q | carry_q;
   assign out_zero   = zero_q;
`ifdef ALU_SEQ_OVERFLOW_EN
   assign out_ovf    = ovf_q;
`endif
   assign alu_a      = run ? a_q[3:0] : 4'h0;
   assign alu_b      = run ? b_q[3:0] : 4'h0;
   assign alu_select = run ? sel_q : 4'h0;
   assign alu_mode   = run & mode_q;
   assign alu_cin    = run ? carry_q : 1'b1;
endmodule

// File: tb/tb_alu181_nibble_sequencer.sv
// tb_alu181_nibble_sequencer: directed checks of the nibble sequencer against a behavioural 181 slice.
module tb_alu181_nibble_sequencer;
   logic        clk = 0, rst = 1;
   logic        in_valid = 0, in_ready, in_mode = 0, in_cin = 1;
   logic [15:0] in_a = 0, in_b = 0, out_f;
   logic [3:0]  in_select = 0, alu_a, alu_b, alu_select, alu_f;
   logic        out_valid, out_ready = 0, out_cout, out_zero;
   logic        alu_mode, alu_cin, alu_cout;
   logic [3:0]  bop;
   logic [4:0]  sum;
`ifdef ALU_SEQ_OVERFLOW_EN
   logic        out_ovf;
`endif
   int          errs = 0, checks = 0;
   logic [15:0] held;

   alu181_nibble_sequencer #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_select(in_select), .in_mode(in_mode), .in_cin(in_cin),
      .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_cout(out_cout),
      .out_zero(out_zero),
`ifdef ALU_SEQ_OVERFLOW_EN
      .out_ovf(out_ovf),
`endif
      .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_mode(alu_mode),
      .alu_cin(alu_cin), .alu_f(alu_f), .alu_cout(alu_cout));

   always #5 clk = ~clk;

   // active-high-data 181 subset: A plus B, A minus B minus 1 (plus carry), XOR
   always_comb begin
      bop = alu_select == 4'b1001 ? alu_b : alu_select == 4'b0110 ? ~alu_b : 4'h0;
      sum = {1'b0, alu_a} + {1'b0, bop} + {4'h0, ~alu_cin};
      alu_f    = alu_mode ? (alu_select == 4'b0110 ? alu_a ^ alu_b : ~alu_a) : sum[3:0];
      alu_cout = alu_mode ? 1'b1 : ~sum[4];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] s, input logic m, input logic c,
                         input logic [15:0] ef, input logic ec, input logic ez);
      int lat;
      chk({tag, "_ready"}, in_ready, 1);
      in_a = a; in_b = b; in_select = s; in_mode = m; in_cin = c; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 1) begin
            chk({tag, "_nib0"}, {alu_a, alu_b, alu_select}, {a[3:0], b[3:0], s});
            chk({tag, "_cin0"}, {alu_mode, alu_cin}, {m, c});
         end
         if (k == 2) chk({tag, "_nib1"}, {alu_a, alu_b}, {a[7:4], b[7:4]});
         if (out_valid) begin
            lat = k;
            break;
         end
         @(posedge clk); #1;
      end
      chk({tag, "_lat"}, lat, 5);
      chk({tag, "_f"}, out_f, ef);
      chk({tag, "_cout"}, out_cout, ec);
      chk({tag, "_zero"}, out_zero, ez);
   endtask

   task automatic release_op(input string tag);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {in_ready, out_valid, out_cout, out_zero}, 4'b1010);
      chk("rst_f", out_f, 0);
      chk("rst_alu", {alu_a, alu_b, alu_select, alu_mode, alu_cin}, 14'h0001);
      rst = 0;
      run_op("add", 16'h1234, 16'h0FFF, 4'b1001, 0, 1, 16'h2233, 1, 0);
      release_op("add");
      run_op("wrap", 16'hFFFF, 16'h0001, 4'b1001, 0, 1, 16'h0000, 0, 1);
      release_op("wrap");
      run_op("sub", 16'h0005, 16'h0007, 4'b0110, 0, 0, 16'hFFFE, 1, 0);
      release_op("sub");
      run_op("xor", 16'hF0F0, 16'hFF00, 4'b0110, 1, 1, 16'h0FF0, 1, 0);
      release_op("xor");
`ifdef ALU_SEQ_OVERFLOW_EN
      run_op("ovf", 16'h7FFF, 16'h0001, 4'b1001, 0, 1, 16'h8000, 1, 0);
      chk("ovf_flag", out_ovf, 1);
      release_op("ovf");
      run_op("noovf", 16'h1234, 16'h0FFF, 4'b1001, 0, 1, 16'h2233, 1, 0);
      chk("noovf_flag", out_ovf, 0);
      release_op("noovf");
`endif
      run_op("bp", 16'h0100, 16'h0200, 4'b1001, 0, 1, 16'h0300, 1, 0);
      held = out_f;
      in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("bp_hold", {in_ready, out_valid, out_f}, {2'b01, held});
      end
      in_valid = 0;
      release_op("bp");
      chk("bp_keep", {out_f, out_cout}, {held, 1'b1});
      @(posedge clk); #1;
      chk("bp_noacc", in_ready, 1);
      in_a = 16'h1111; in_b = 16'h2222; in_select = 4'b1001; in_mode = 0; in_cin = 1; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #1;
      chk("mid_run", {in_ready, out_valid}, 2'b00);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("mid_rst_state", {in_ready, out_valid, out_cout, out_zero, alu_cin}, 5'b10101);
      chk("mid_rst_f", out_f, 0);
      chk("mid_rst_alu", {alu_a, alu_b}, 0);
      run_op("fresh", 16'h0001, 16'h0001, 4'b1001, 0, 1, 16'h0002, 1, 0);
      release_op("fresh");
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
